// File: rtl/dac_pattern_pkg.sv
// -----------------------------------------------------------------------------
// dac_pattern_pkg
// Shared types and helpers for the DAC test-pattern generator.
//   mode_e       : runtime pattern selector (RAMP, CONST, TOGGLE, PRBS/reserved)
//   state_e      : run-control states (IDLE, RUN, STOP)
//   PRBS15_*     : polynomial tap mask and width for x^15 + x^14 + 1
//   prbs15_next  : one LFSR step (Fibonacci form, shifts towards the MSB)
// Build option: DAC_PATTERN_PRBS_EN enables the PRBS15 pattern on mode 3; the
// helpers here are harmless when it is left undefined.
// -----------------------------------------------------------------------------
package dac_pattern_pkg;

   typedef enum logic [1:0] {
      MODE_RAMP   = 2'd0,
      MODE_CONST  = 2'd1,
      MODE_TOGGLE = 2'd2,
      MODE_PRBS   = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } state_e;

   localparam int          PRBS15_W    = 15;
   // Feedback taps for x^15 + x^14 + 1: register stages 15 and 14 -> bits 14 and 13.
   localparam logic [14:0] PRBS15_TAPS = 15'h6000;

   function automatic logic [14:0] prbs15_next(input logic [14:0] s);
      return {s[13:0], ^(s & PRBS15_TAPS)};
   endfunction

endpackage

// File: rtl/dac_pattern_lane.sv
// -----------------------------------------------------------------------------
// dac_pattern_lane
// One DAC channel: ramp accumulator, optional PRBS15 LFSR and the registered
// DDR sample pair selected by the captured mode.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   from_idle    : generator is idle this cycle; seeds are used as current state
//   beat_en      : a sample pair is produced on this edge
//   mode         : captured pattern mode
//   step         : captured ramp increment
//   const_val    : captured constant for CONST/TOGGLE
//   d1, d2       : registered rising/falling-slot samples (0 when no beat)
// Build option: DAC_PATTERN_PRBS_EN adds the per-lane PRBS15 LFSR (seed
// CH_IDX+1); without it mode 3 outputs zero and no LFSR exists.
// -----------------------------------------------------------------------------
module dac_pattern_lane
   import dac_pattern_pkg::*;
#(
   parameter int              DW        = 16,
   parameter int              CH_IDX    = 0,
   parameter logic [DW-1:0]   CH_OFFSET = 16'h4000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          from_idle,
   input  logic          beat_en,
   input  mode_e         mode,
   input  logic [DW-1:0] step,
   input  logic [DW-1:0] const_val,
   output logic [DW-1:0] d1,
   output logic [DW-1:0] d2
);

   localparam logic [DW-1:0] RAMP_SEED = DW'(CH_IDX * CH_OFFSET);

   logic [DW-1:0] acc_q, acc_d, acc_cur, ramp_d2;
   logic [DW-1:0] d1_q, d1_d, d2_q, d2_d;
   logic [DW-1:0] prbs_d1, prbs_d2;

   // While idle the accumulator is forced to its seed, so a start always
   // begins from CH_IDX*CH_OFFSET regardless of what was held before.
   always_comb begin
      acc_cur = from_idle ? RAMP_SEED : acc_q;
      ramp_d2 = acc_cur + step;
   end

`ifdef DAC_PATTERN_PRBS_EN
   localparam logic [14:0] LFSR_SEED = 15'(CH_IDX + 1);

   logic [14:0] lfsr_q, lfsr_d, lfsr_cur, lfsr_mid;

   // Zero-extend or truncate the 15-bit LFSR state to the sample width.
   function automatic logic [DW-1:0] to_sample(input logic [14:0] s);
      logic [DW+14:0] wide;
      wide = {{DW{1'b0}}, s};
      return wide[DW-1:0];
   endfunction

   always_comb begin
      lfsr_cur = from_idle ? LFSR_SEED : lfsr_q;
      lfsr_mid = prbs15_next(lfsr_cur);
      prbs_d1  = to_sample(lfsr_cur);
      prbs_d2  = to_sample(lfsr_mid);
      lfsr_d   = lfsr_cur;
      // Two samples per cycle, so the LFSR advances twice per beat.
      if (beat_en && mode == MODE_PRBS) begin
         lfsr_d = prbs15_next(lfsr_mid);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   // Mode 3 is reserved: samples are zero.
   assign prbs_d1 = '0;
   assign prbs_d2 = '0;
`endif

   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      acc_d = acc_cur;
      d1_d  = '0;
      d2_d  = '0;
      if (beat_en) begin
         case (mode)
            MODE_RAMP: begin
               d1_d  = acc_cur;
               d2_d  = ramp_d2;
               acc_d = ramp_d2 + step;
            end
            MODE_CONST: begin
               d1_d = const_val;
               d2_d = const_val;
            end
            MODE_TOGGLE: begin
               d1_d = const_val;
               d2_d = ~const_val;
            end
            default: begin
               d1_d = prbs_d1;
               d2_d = prbs_d2;
            end
         endcase
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= RAMP_SEED;
         d1_q  <= '0;
         d2_q  <= '0;
      end else begin
         acc_q <= acc_d;
         d1_q  <= d1_d;
         d2_q  <= d2_d;
      end
   end

   assign d1 = d1_q;
   assign d2 = d2_q;

endmodule

// File: rtl/dac_pattern_gen.sv
// -----------------------------------------------------------------------------
// dac_pattern_gen
// Multi-channel DAC test-pattern generator producing DDR sample pairs and a
// frame strobe. Holds the run-control FSM, the frame counter and the per-frame
// configuration capture; one dac_pattern_lane per channel builds the samples.
// Ports:
//   clk, rst_n          : DAC reference clock, asynchronous active-low reset
//   enable              : level-sensitive run request
//   mode                : 0 RAMP, 1 CONST, 2 TOGGLE, 3 PRBS15 or reserved
//   step                : ramp increment per sample
//   const_val           : value for CONST/TOGGLE
//   busy                : high while a frame is being streamed (RUN or STOP)
//   frame_d1, frame_d2  : frame strobe for the rising/falling DDR slot
//   data_d1, data_d2    : channel k in bits [k*DW +: DW]
// Build option: DAC_PATTERN_PRBS_EN turns mode 3 into PRBS15; otherwise mode 3
// is reserved and outputs zero data with a normal frame strobe.
// -----------------------------------------------------------------------------
module dac_pattern_gen
   import dac_pattern_pkg::*;
#(
   parameter int            CHANNELS     = 2,
   parameter int            DW           = 16,
   parameter int            FRAME_CYCLES = 2,
   parameter logic [DW-1:0] CH_OFFSET    = 16'h4000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [1:0]             mode,
   input  logic [DW-1:0]          step,
   input  logic [DW-1:0]          const_val,
   output logic                   busy,
   output logic                   frame_d1,
   output logic                   frame_d2,
   output logic [CHANNELS*DW-1:0] data_d1,
   output logic [CHANNELS*DW-1:0] data_d2
);

   localparam int             FCW     = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [FCW-1:0] LAST_FC = FCW'(FRAME_CYCLES - 1);

   state_e         state_q, state_d;
   logic [FCW-1:0] fcnt_q, fcnt_d;
   logic           busy_q, busy_d;
   logic           frame_q, frame_d;
   mode_e          mode_q, mode_d;
   logic [DW-1:0]  step_q, step_d;
   logic [DW-1:0]  cval_q, cval_d;

   logic           beat_en, from_idle, last_fc, cfg_load;

   // fcnt_q is the frame cycle of the beat currently on the outputs; fcnt_d is
   // the frame cycle of the beat produced on this edge.
   always_comb begin
      state_d   = state_q;
      fcnt_d    = fcnt_q;
      beat_en   = 1'b0;
      from_idle = (state_q == ST_IDLE);
      last_fc   = (fcnt_q == LAST_FC);
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d = ST_RUN;
               fcnt_d  = '0;
               beat_en = 1'b1;
            end
         end
         ST_RUN, ST_STOP: begin
            if (!enable && last_fc) begin
               // Frame complete with no run request: stop cleanly.
               state_d = ST_IDLE;
               fcnt_d  = '0;
            end else begin
               // RUN and STOP stream identically; STOP only records that
               // the stream ends at the frame boundary unless re-enabled.
               state_d = enable ? ST_RUN : ST_STOP;
               fcnt_d  = last_fc ? '0 : fcnt_q + 1'b1;
               beat_en = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Configuration is sampled only with the beat that opens a frame.
   always_comb begin
      cfg_load = beat_en && (fcnt_d == '0);
      mode_d   = cfg_load ? mode_e'(mode) : mode_q;
      step_d   = cfg_load ? step          : step_q;
      cval_d   = cfg_load ? const_val     : cval_q;
      busy_d   = (state_d != ST_IDLE);
      frame_d  = cfg_load;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         fcnt_q  <= '0;
         busy_q  <= 1'b0;
         frame_q <= 1'b0;
         mode_q  <= MODE_RAMP;
         step_q  <= '0;
         cval_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         busy_q  <= busy_d;
         frame_q <= frame_d;
         mode_q  <= mode_d;
         step_q  <= step_d;
         cval_q  <= cval_d;
      end
   end

   assign busy     = busy_q;
   assign frame_d1 = frame_q;
   assign frame_d2 = frame_q;

   // Lanes see the configuration that applies to the beat being produced:
   // the live inputs on a frame-opening edge, the captured copy otherwise.
   for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
      dac_pattern_lane #(
         .DW        (DW),
         .CH_IDX    (k),
         .CH_OFFSET (CH_OFFSET)
      ) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .from_idle (from_idle),
         .beat_en   (beat_en),
         .mode      (mode_d),
         .step      (step_d),
         .const_val (cval_d),
         .d1        (data_d1[k*DW +: DW]),
         .d2        (data_d2[k*DW +: DW])
      );
   end

endmodule

// File: tb/tb_dac_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_dac_pattern_gen
// Three generator instances share one stimulus stream:
//   inst0: 2 channels, frame of 2 cycles
//   inst1: 3 channels, frame of 4 cycles
//   inst2: 1 channel,  frame of 1 cycle
// A behavioural model predicts each instance's registered outputs per cycle
// and queues them; a monitor pops and compares one entry per clock.
// -----------------------------------------------------------------------------
module tb_dac_pattern_gen;

   localparam int          NI     = 3;
   localparam int          MAXCH  = 3;
   localparam logic [15:0] OFFSET = 16'h4000;
   localparam int          CH_OF [NI] = '{2, 3, 1};
   localparam int          FC_OF [NI] = '{2, 4, 1};

   typedef struct packed {
      logic        busy;
      logic        f1;
      logic        f2;
      logic [47:0] d1;
      logic [47:0] d2;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [15:0] step = 16'd0;
   logic [15:0] const_val = 16'd0;

   logic        busy_a, f1_a, f2_a;
   logic [31:0] d1_a, d2_a;
   logic        busy_b, f1_b, f2_b;
   logic [47:0] d1_b, d2_b;
   logic        busy_c, f1_c, f2_c;
   logic [15:0] d1_c, d2_c;

   exp_t act [NI];
   exp_t exp_q [NI][$];
   exp_t mon_e;

   int checks = 0;
   int errors = 0;
   bit rst_req = 1'b0;

   // Model state
   bit          active [NI];
   int          pos    [NI];
   logic [15:0] acc    [NI][MAXCH];
   logic [14:0] lfsr   [NI][MAXCH];
   logic [1:0]  cm     [NI];
   logic [15:0] cs     [NI];
   logic [15:0] cc     [NI];

   always #5 clk = ~clk;

   dac_pattern_gen #(.CHANNELS(2), .DW(16), .FRAME_CYCLES(2), .CH_OFFSET(16'h4000)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .step(step),
      .const_val(const_val), .busy(busy_a), .frame_d1(f1_a), .frame_d2(f2_a),
      .data_d1(d1_a), .data_d2(d2_a));

   dac_pattern_gen #(.CHANNELS(3), .DW(16), .FRAME_CYCLES(4), .CH_OFFSET(16'h4000)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .step(step),
      .const_val(const_val), .busy(busy_b), .frame_d1(f1_b), .frame_d2(f2_b),
      .data_d1(d1_b), .data_d2(d2_b));

   dac_pattern_gen #(.CHANNELS(1), .DW(16), .FRAME_CYCLES(1), .CH_OFFSET(16'h4000)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .step(step),
      .const_val(const_val), .busy(busy_c), .frame_d1(f1_c), .frame_d2(f2_c),
      .data_d1(d1_c), .data_d2(d2_c));

   always_comb begin
      act[0].busy = busy_a; act[0].f1 = f1_a; act[0].f2 = f2_a;
      act[0].d1 = {16'h0, d1_a}; act[0].d2 = {16'h0, d2_a};
      act[1].busy = busy_b; act[1].f1 = f1_b; act[1].f2 = f2_b;
      act[1].d1 = d1_b; act[1].d2 = d2_b;
      act[2].busy = busy_c; act[2].f1 = f1_c; act[2].f2 = f2_c;
      act[2].d1 = {32'h0, d1_c}; act[2].d2 = {32'h0, d2_c};
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   // PRBS15 x^15+x^14+1: new bit = bit14 ^ bit13, shifted in at the bottom.
   function automatic logic [14:0] prbs_next(input logic [14:0] x);
      int v;
      v = int'(x);
      return 15'(((v << 1) | (((v >> 14) ^ (v >> 13)) & 1)) & 32'h7fff);
   endfunction

   // Predicts the outputs that appear after the coming clock edge.
   task automatic model_step(input int i, output exp_t e);
      logic [15:0] s1, s2;
      e = '0;
      if (!rst_n) begin
         active[i] = 1'b0;
         return;
      end
      if (!active[i]) begin
         if (!enable) return;
         active[i] = 1'b1;
         pos[i] = 0;
         for (int k = 0; k < MAXCH; k++) begin
            acc[i][k]  = 16'(k * OFFSET);
            lfsr[i][k] = 15'(k + 1);
         end
      end else if (!enable && pos[i] == FC_OF[i] - 1) begin
         active[i] = 1'b0;
         return;
      end else begin
         pos[i] = (pos[i] + 1) % FC_OF[i];
      end
      if (pos[i] == 0) begin
         cm[i] = mode;
         cs[i] = step;
         cc[i] = const_val;
      end
      e.busy = 1'b1;
      e.f1   = (pos[i] == 0);
      e.f2   = (pos[i] == 0);
      for (int k = 0; k < CH_OF[i]; k++) begin
         case (cm[i])
            2'd0: begin
               s1 = acc[i][k];
               s2 = 16'(acc[i][k] + cs[i]);
               acc[i][k] = 16'(acc[i][k] + 2 * cs[i]);
            end
            2'd1: begin s1 = cc[i]; s2 = cc[i]; end
            2'd2: begin s1 = cc[i]; s2 = ~cc[i]; end
            default: begin
`ifdef DAC_PATTERN_PRBS_EN
               s1 = {1'b0, lfsr[i][k]};
               s2 = {1'b0, prbs_next(lfsr[i][k])};
               lfsr[i][k] = prbs_next(prbs_next(lfsr[i][k]));
`else
               s1 = 16'h0;
               s2 = 16'h0;
`endif
            end
         endcase
         e.d1[k*16 +: 16] = s1;
         e.d2[k*16 +: 16] = s2;
      end
   endtask

   task automatic cycle(input bit en, input logic [1:0] m, input logic [15:0] st,
                        input logic [15:0] cv);
      exp_t e;
      @(negedge clk);
      enable    = en;
      mode      = m;
      step      = st;
      const_val = cv;
      if (rst_n != rst_req) begin
         rst_n = rst_req;
         if (!rst_req) begin
            #1;
            for (int i = 0; i < NI; i++)
               check($sformatf("inst%0d async reset outputs", i), 64'(act[i]), 64'(0));
            for (int i = 0; i < NI; i++)
               check($sformatf("inst%0d async reset data", i), {16'h0, act[i].d1}, 64'(0));
         end
      end
      for (int i = 0; i < NI; i++) begin
         model_step(i, e);
         exp_q[i].push_back(e);
      end
   endtask

   // Monitor: one expected entry per instance per clock.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NI; i++) begin
         if (exp_q[i].size() != 0) begin
            mon_e = exp_q[i].pop_front();
            check($sformatf("inst%0d busy", i), 64'(act[i].busy), 64'(mon_e.busy));
            check($sformatf("inst%0d frame", i), {62'h0, act[i].f1, act[i].f2},
                  {62'h0, mon_e.f1, mon_e.f2});
            check($sformatf("inst%0d data_d1", i), {16'h0, act[i].d1}, {16'h0, mon_e.d1});
            check($sformatf("inst%0d data_d2", i), {16'h0, act[i].d2}, {16'h0, mon_e.d2});
         end
      end
   end

   initial begin
      bit          en_r;
      logic [1:0]  m_r;
      logic [15:0] st_r, cv_r;
      for (int i = 0; i < NI; i++) active[i] = 1'b0;
      en_r = 1'b0; m_r = 2'd0; st_r = 16'd1; cv_r = 16'd0;

      #1;
      for (int i = 0; i < NI; i++) begin
         check($sformatf("inst%0d reset busy", i), 64'(act[i].busy), 64'(0));
         check($sformatf("inst%0d reset data", i), {16'h0, act[i].d1 | act[i].d2}, 64'(0));
      end
      repeat (3) cycle(1'b0, 2'd0, 16'd0, 16'd0);
      rst_req = 1'b1;
      repeat (2) cycle(1'b0, 2'd0, 16'd1, 16'd0);

      // RAMP step 1 with enable held
      repeat (12) cycle(1'b1, 2'd0, 16'd1, 16'd0);
      // Stop requests of varying length, re-raised during the frame tail
      for (int g = 1; g <= 5; g++) begin
         repeat (g) cycle(1'b0, 2'd0, 16'd1, 16'd0);
         repeat (3) cycle(1'b1, 2'd0, 16'd1, 16'd0);
      end
      // RAMP step 8000 exercises the wrap
      repeat (10) cycle(1'b1, 2'd0, 16'h8000, 16'd0);
      // CONST then TOGGLE written mid-frame
      for (int n = 0; n < 6; n++) begin
         cycle(1'b1, 2'd1, 16'd0, 16'hA5A5);
         cycle(1'b1, 2'd2, 16'd0, 16'hA5A5);
         cycle(1'b1, 2'd2, 16'd0, 16'hA5A5);
      end
      // Mode 3 (PRBS15 or reserved depending on build)
      repeat (40) cycle(1'b1, 2'd3, 16'd0, 16'd0);
      repeat (4) cycle(1'b0, 2'd3, 16'd0, 16'd0);
      // Mode 3 fresh from idle: seeds visible on the first beat
      repeat (6) cycle(1'b1, 2'd3, 16'd0, 16'd0);
      repeat (4) cycle(1'b0, 2'd0, 16'd0, 16'd0);

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 7) == 0) en_r = !en_r;
         if ($urandom_range(0, 3) == 0) begin
            m_r  = 2'($urandom_range(0, 3));
            st_r = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 3));
            cv_r = 16'($urandom);
         end
         cycle(en_r, m_r, st_r, cv_r);
      end

      // Async reset in the middle of a running ramp, then restart
      repeat (5) cycle(1'b1, 2'd0, 16'd1, 16'd0);
      rst_req = 1'b0;
      repeat (2) cycle(1'b1, 2'd0, 16'd1, 16'd0);
      rst_req = 1'b1;
      repeat (10) cycle(1'b1, 2'd0, 16'd1, 16'd0);
      repeat (6) cycle(1'b0, 2'd0, 16'd1, 16'd0);

      @(negedge clk);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dac_pattern_gen.md
# dac_pattern_gen

Parametrised multi-channel DAC test-pattern generator producing DDR sample pairs and a frame strobe for any number of parallel DAC data interfaces. It replaces the fixed free-running counter stub with runtime-selectable patterns, programmable frame period, per-channel offsets and clean start/stop at frame boundaries. It sits between the control register bank and the per-pin DDR output/differential buffer stage.

## Interface
- CHANNELS, 2: number of DAC data interfaces.
- DW, 16: sample width per channel.
- FRAME_CYCLES, 2: frame period in clock cycles (>= 1).
- CH_OFFSET, 16'h4000: ramp start offset between adjacent channels.

- clk  in  1  DAC reference clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run request; level-sensitive.
- mode  in  2  0 RAMP, 1 CONST, 2 TOGGLE, 3 PRBS (macro-dependent).
- step  in  DW  ramp increment per sample.
- const_val  in  DW  value for CONST/TOGGLE.
- busy  out  1  high in RUN or STOP.
- frame_d1, frame_d2  out  1 each  frame bit for rising/falling DDR slot.
- data_d1, data_d2  out  CHANNELS*DW each  channel k in bits [k*DW +: DW]; d1 = rising-edge sample, d2 = falling-edge sample.

## Operation
- States: IDLE, RUN, STOP. Reset -> IDLE.
- IDLE -> RUN: on edge sampling enable=1. RUN -> STOP: enable=0 and not last cycle of frame. RUN -> IDLE: enable=0 on last frame cycle. STOP -> IDLE: last frame cycle completes. STOP -> RUN: enable=1 again; stream continues with no gap or frame restart.
- Frame counter 0..FRAME_CYCLES-1, wraps; frame_d1 = frame_d2 = 1 on cycle 0 of each frame, else 0. FRAME_CYCLES=1: frame high every running cycle.
- mode, step, const_val captured at frame cycle 0 only; mid-frame changes ignored until next frame.
- RAMP: two samples per cycle; channel k accumulator a; d1 = a, d2 = a+step, a += 2*step each cycle; mod 2^DW wrap. On leaving IDLE, a = k*CH_OFFSET mod 2^DW.
- CONST: d1 = d2 = const_val, all channels.
- TOGGLE: d1 = const_val, d2 = ~const_val.
- Mode switch at frame boundary: RAMP accumulators hold value (not reseeded) while another mode is active.
- Reserved mode: data outputs 0, frame strobe unaffected.
- IDLE: all outputs 0, accumulators and LFSRs reseeded.

## Timing
- All outputs registered; reset value 0 for busy, frame_d1/d2, data_d1/d2.
- Edge sampling enable=1 in IDLE loads the first beat (frame cycle 0); visible the following cycle. busy rises on the same edge.
- Final beat is last frame cycle; outputs 0 and busy 0 after next edge.
- Async reset mid-frame: immediate return to IDLE, outputs 0; no partial-frame completion.

## Configuration
- DAC_PATTERN_PRBS_EN defined: mode 3 = PRBS15 (x^15+x^14+1), one LFSR per channel seeded 15'(k+1), advanced once per sample (twice per cycle); sample = LFSR state zero-extended/truncated to DW.
- Not defined: mode 3 reserved (data 0); no LFSR logic synthesised.

## Structure
- Package dac_pattern_pkg: mode enum, state enum, PRBS15 polynomial/seed constants, next-LFSR function.
- Sub-module dac_pattern_lane: one channel's ramp accumulator, optional LFSR and sample mux; instantiated CHANNELS times. Top holds FSM, frame counter, config capture.

## Test plan
- CHANNELS=2, DW=16, FRAME_CYCLES=2, RAMP step=1, enable held -> ch0 d1/d2 = 0/1, 2/3, 4/5…; ch1 = 4000/4001…; frame 1,0,1,0.
- RAMP step=16'h8000 -> ch0 d1 = 0 always, d2 = 8000; wrap checked.
- CONST 16'hA5A5 then TOGGLE written mid-frame -> change takes effect exactly at next frame cycle 0; TOGGLE gives A5A5/5A5A.
- FRAME_CYCLES=4, drop enable on frame cycle 1 -> cycles 2,3 still output, busy falls after cycle 3; re-raise during STOP -> no gap, frame continues.
- With DAC_PATTERN_PRBS_EN, mode 3 -> ch0 first samples 0001/0002 (seed 1, zero-extended); ch1 seed 2; sequence period 32767 samples.
- rst_n asserted mid-RUN -> all outputs 0 immediately; enable after release restarts ramp at k*CH_OFFSET.
